// File: rtl/rcc_sync_pkg.sv
// Shared constants and helpers for the RCC status synchroniser/filter slice.
// Holds the legal synchroniser depth range and the effective filter length rule.
package rcc_sync_pkg;

  localparam int unsigned STAGE_NUM_MIN = 2;
  localparam int unsigned STAGE_NUM_MAX = 4;
  localparam int unsigned FILT_W_DEF    = 4;

  // Effective filter length: a disabled filter or a zero length behaves as one cycle.
  function automatic int unsigned calc_leff(input logic en, input int unsigned len);
    return (en && (len != 0)) ? len : 1;
  endfunction

endpackage

// File: rtl/rcc_status_sync_filter_if.sv
// Status/config bundle between the RCC register block (master) and the filter (slave).
// The register side drives the raw inputs and controls; the filter returns levels and events.
interface rcc_status_sync_filter_if #(
  parameter int unsigned CH_NUM = 11,
  parameter int unsigned FILT_W = rcc_sync_pkg::FILT_W_DEF
);

  logic [CH_NUM-1:0] async_in;
  logic [FILT_W-1:0] filt_len;
  logic [CH_NUM-1:0] filt_en;
  logic [CH_NUM-1:0] irq_en;
  logic [CH_NUM-1:0] flag_clr;
  logic [CH_NUM-1:0] sync_level;
  logic [CH_NUM-1:0] rise_pulse;
  logic [CH_NUM-1:0] fall_pulse;
  logic [CH_NUM-1:0] event_flag;
  logic              irq;

  modport master (
    output async_in, filt_len, filt_en, irq_en, flag_clr,
    input  sync_level, rise_pulse, fall_pulse, event_flag, irq
  );

  modport slave (
    input  async_in, filt_len, filt_en, irq_en, flag_clr,
    output sync_level, rise_pulse, fall_pulse, event_flag, irq
  );

endinterface

// File: rtl/rcc_sync_filter_ch.sv
// One status channel: synchroniser chain, persistence filter, edge pulses and sticky flag.
// A change on the synchronised input must hold for Leff consecutive cycles to reach sync_level.
module rcc_sync_filter_ch
  import rcc_sync_pkg::*;
#(
  parameter int unsigned STAGE_NUM = 2,
  parameter int unsigned FILT_W    = FILT_W_DEF,
  parameter logic        RST_VAL   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              async_in,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              filt_en,
  input  logic              flag_clr,
  output logic              sync_level,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic              event_flag
);

  if ((STAGE_NUM < STAGE_NUM_MIN) || (STAGE_NUM > STAGE_NUM_MAX)) begin : g_bad_stage
    $error("rcc_sync_filter_ch: STAGE_NUM out of range");
  end

  logic [STAGE_NUM-1:0] sync_q;
  logic [FILT_W-1:0]    cnt;
  logic [FILT_W-1:0]    cnt_lim;
  logic                 s;
  logic                 differ;
  logic                 toggle;

  assign s       = sync_q[STAGE_NUM-1];
  assign cnt_lim = FILT_W'(calc_leff(filt_en, 32'(filt_len)) - 1);
  assign differ  = s ^ sync_level;
  // Compared against the live limit so a shortened filt_len takes effect mid-count.
  assign toggle  = differ && (cnt >= cnt_lim);

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGE_NUM{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGE_NUM-2:0], async_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!differ || toggle) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_level <= RST_VAL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      if (toggle) begin
        sync_level <= s;
      end
      rise_pulse <= toggle & s;
      fall_pulse <= toggle & ~s;
    end
  end

  // A new edge outranks a simultaneous clear so no event is ever lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_flag <= 1'b0;
    end else if (rise_pulse || fall_pulse) begin
      event_flag <= 1'b1;
    end else if (flag_clr) begin
      event_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/rcc_status_sync_filter.sv
// Multi-channel RCC status synchroniser/filter: CH_NUM independent channels sharing filt_len,
// plus a registered interrupt request from the enabled sticky flags.
module rcc_status_sync_filter
  import rcc_sync_pkg::*;
#(
  parameter int unsigned       CH_NUM    = 11,
  parameter int unsigned       STAGE_NUM = 2,
  parameter int unsigned       FILT_W    = FILT_W_DEF,
  parameter logic [CH_NUM-1:0] RST_VAL   = {CH_NUM{1'b0}}
) (
  input  logic                     rcc_rcc_hclk,
  input  logic                     rcc_rcc_sync_rst,
  rcc_status_sync_filter_if.slave  bus
);

  wire [CH_NUM-1:0] sync_level_w;
  wire [CH_NUM-1:0] rise_pulse_w;
  wire [CH_NUM-1:0] fall_pulse_w;
  wire [CH_NUM-1:0] event_flag_w;
  logic             irq_q;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    rcc_sync_filter_ch #(
      .STAGE_NUM (STAGE_NUM),
      .FILT_W    (FILT_W),
      .RST_VAL   (RST_VAL[i])
    ) u_ch (
      .clk        (rcc_rcc_hclk),
      .rst        (rcc_rcc_sync_rst),
      .async_in   (bus.async_in[i]),
      .filt_len   (bus.filt_len),
      .filt_en    (bus.filt_en[i]),
      .flag_clr   (bus.flag_clr[i]),
      .sync_level (sync_level_w[i]),
      .rise_pulse (rise_pulse_w[i]),
      .fall_pulse (fall_pulse_w[i]),
      .event_flag (event_flag_w[i])
    );
  end

  always_ff @(posedge rcc_rcc_hclk or posedge rcc_rcc_sync_rst) begin
    if (rcc_rcc_sync_rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(event_flag_w & bus.irq_en);
    end
  end

  assign bus.sync_level = sync_level_w;
  assign bus.rise_pulse = rise_pulse_w;
  assign bus.fall_pulse = fall_pulse_w;
  assign bus.event_flag = event_flag_w;
  assign bus.irq        = irq_q;

endmodule

// File: tb/tb_rcc_status_sync_filter.sv
// Scoreboard bench for rcc_status_sync_filter: a cycle reference model queues expected outputs,
// a negedge monitor compares them, and directed probes time the key latencies.
module tb_rcc_status_sync_filter;
  import rcc_sync_pkg::*;

  localparam int CH  = 11;
  localparam int STG = 2;
  localparam int FW  = 4;
  localparam logic [CH-1:0] RST_VAL = '0;

  typedef struct packed {
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] flag;
    logic          irq;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  obs_t exp_q[$];

  rcc_status_sync_filter_if #(.CH_NUM(CH), .FILT_W(FW)) bus ();

  rcc_status_sync_filter #(
    .CH_NUM(CH), .STAGE_NUM(STG), .FILT_W(FW), .RST_VAL(RST_VAL)
  ) dut (
    .rcc_rcc_hclk     (clk),
    .rcc_rcc_sync_rst (rst),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: s is the input as seen STG edges ago; sync_level follows s once
  // s has disagreed with it for Leff consecutive edges.
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_level, m_rise, m_fall, m_flag;
  logic          m_irq;
  int            m_run[CH];

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < STG; k++) hist.push_back(RST_VAL);
    m_level = RST_VAL;
    m_rise  = '0;
    m_fall  = '0;
    m_flag  = '0;
    m_irq   = 1'b0;
    for (int i = 0; i < CH; i++) m_run[i] = 0;
  endtask

  task automatic model_step();
    logic [CH-1:0] s_old, n_level, n_rise, n_fall, n_flag;
    logic          n_irq;
    int            leff;
    s_old = hist.pop_front();
    hist.push_back(bus.async_in);
    for (int i = 0; i < CH; i++) begin
      leff = (bus.filt_en[i] && bus.filt_len != 0) ? int'(bus.filt_len) : 1;
      n_level[i] = m_level[i];
      n_rise[i]  = 1'b0;
      n_fall[i]  = 1'b0;
      if (s_old[i] == m_level[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] >= leff) begin
          n_level[i] = s_old[i];
          n_rise[i]  = s_old[i];
          n_fall[i]  = !s_old[i];
          m_run[i]   = 0;
        end
      end
      n_flag[i] = (m_rise[i] || m_fall[i]) ? 1'b1 : (bus.flag_clr[i] ? 1'b0 : m_flag[i]);
    end
    n_irq   = |(m_flag & bus.irq_en);
    m_level = n_level;
    m_rise  = n_rise;
    m_fall  = n_fall;
    m_flag  = n_flag;
    m_irq   = n_irq;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.level = m_level;
    o.rise  = m_rise;
    o.fall  = m_fall;
    o.flag  = m_flag;
    o.irq   = m_irq;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.level = bus.sync_level;
    o.rise  = bus.rise_pulse;
    o.fall  = bus.fall_pulse;
    o.flag  = bus.event_flag;
    o.irq   = bus.irq;
    return o;
  endfunction

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_step();
    exp_q.push_back(model_obs());
  end

  always @(negedge clk) begin
    obs_t want;
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      check("scoreboard", 64'(dut_obs()), 64'(want));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_edge(input int ch, input bit rising, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if ((rising ? bus.rise_pulse[ch] : bus.fall_pulse[ch]) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic seen;
    obs_t want;

    model_reset();
    bus.async_in = '0;
    bus.filt_len = '0;
    bus.filt_en  = '0;
    bus.irq_en   = '0;
    bus.flag_clr = '0;
    cycles(3);
    rst = 1'b0;
    check("reset_state", 64'(dut_obs()), 64'(0));
    cycles(2);

    // Bypass channel: input to level in STAGE_NUM + 1 cycles.
    bus.async_in[3] = 1'b1;
    wait_edge(3, 1'b1, lat);
    check("ch3_bypass_latency", 64'(lat), 64'(3));
    check("ch3_level", 64'(bus.sync_level[3]), 64'(1));

    // Filtered channel: a 3-cycle glitch is dropped, a stable change arrives after 2+4.
    bus.filt_en[0] = 1'b1;
    bus.filt_len   = 4'd4;
    cycles(1);
    bus.async_in[0] = 1'b1;
    cycles(3);
    bus.async_in[0] = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= bus.rise_pulse[0] | bus.fall_pulse[0] | bus.sync_level[0];
    end
    check("ch0_glitch_suppressed", 64'(seen), 64'(0));
    bus.async_in[0] = 1'b1;
    wait_edge(0, 1'b1, lat);
    check("ch0_filtered_latency", 64'(lat), 64'(6));

    // Fall on channel 5 with interrupts enabled.
    bus.irq_en[5]   = 1'b1;
    bus.async_in[5] = 1'b1;
    cycles(6);
    bus.flag_clr[5] = 1'b1;
    cycles(1);
    bus.flag_clr[5] = 1'b0;
    cycles(2);
    check("ch5_flag_cleared", 64'(bus.event_flag[5]), 64'(0));
    check("irq_low_after_clear", 64'(bus.irq), 64'(0));
    bus.async_in[5] = 1'b0;
    wait_edge(5, 1'b0, lat);
    check("ch5_fall_latency", 64'(lat), 64'(3));
    @(negedge clk);
    check("ch5_pulse_one_cycle", 64'(bus.fall_pulse[5]), 64'(0));
    check("ch5_flag_set", 64'(bus.event_flag[5]), 64'(1));
    check("irq_not_yet", 64'(bus.irq), 64'(0));
    @(negedge clk);
    check("irq_set", 64'(bus.irq), 64'(1));

    // Clear coinciding with a new rise: the set wins.
    bus.flag_clr[5] = 1'b1;
    cycles(1);
    bus.flag_clr[5] = 1'b0;
    cycles(1);
    check("ch5_flag_cleared_again", 64'(bus.event_flag[5]), 64'(0));
    bus.async_in[5] = 1'b1;
    wait_edge(5, 1'b1, lat);
    bus.flag_clr[5] = 1'b1;
    @(negedge clk);
    bus.flag_clr[5] = 1'b0;
    check("ch5_set_wins", 64'(bus.event_flag[5]), 64'(1));

    // Shrinking filt_len while channel 1 has counted to 5.
    bus.filt_en[1] = 1'b1;
    bus.filt_len   = 4'd8;
    cycles(2);
    bus.async_in[1] = 1'b1;
    cycles(7);
    check("ch1_still_counting", 64'(bus.sync_level[1]), 64'(0));
    bus.filt_len = 4'd3;
    @(negedge clk);
    check("ch1_len_shrink", 64'({bus.sync_level[1], bus.rise_pulse[1]}), 64'(2'b11));

    // Asynchronous reset in the middle of a count on every channel.
    bus.filt_len = 4'd8;
    bus.filt_en  = '1;
    cycles(2);
    bus.async_in = ~bus.async_in;
    cycles(5);
    #1 rst = 1'b1;
    #1;
    want       = '0;
    want.level = RST_VAL;
    check("async_reset", 64'(dut_obs()), 64'(want));
    bus.async_in = RST_VAL;
    cycles(2);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= (|bus.rise_pulse) | (|bus.fall_pulse);
    end
    check("no_pulse_after_reset", 64'(seen), 64'(0));

    // Randomised traffic, including one reset pulse partway through.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (n == 1500) begin
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(7) == 0) bus.async_in[i] = ~bus.async_in[i];
      end
      if ($urandom_range(99) == 0)  bus.filt_len = FW'($urandom_range(15));
      if ($urandom_range(199) == 0) bus.filt_en  = CH'($urandom);
      if ($urandom_range(199) == 0) bus.irq_en   = CH'($urandom);
      bus.flag_clr = CH'($urandom & $urandom & $urandom);
    end
    bus.flag_clr = '0;
    cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rcc_status_sync_filter.md
Name: rcc_status_sync_filter

Overview:
- Parametrised multi-channel successor to the per-signal RCC status synchronisers (oscillator/PLL ready, CSS fail).
- Each asynchronous status input passes through an N-stage synchroniser, then a programmable glitch filter.
- Produces filtered levels, one-cycle edge pulses, sticky W1C event flags and a masked interrupt request, all in the hclk domain.
- Sits between the oscillator/PLL analog wrappers and the RCC register/interrupt logic.

Parameters:
- CH_NUM, 11, number of status channels.
- STAGE_NUM, 2, synchroniser flop stages; legal range 2..4.
- FILT_W, 4, width of the filter length and of each per-channel counter.
- RST_VAL, {CH_NUM{1'b0}}, per-channel reset value of the sync chain and filtered level.

Ports:
- rcc_rcc_hclk  in  1  block clock.
- rcc_rcc_sync_rst  in  1  reset; asynchronous assert, active-high.
- async_in  in  CH_NUM  raw asynchronous status inputs.
- filt_len  in  FILT_W  quasi-static filter length L in hclk cycles; shared by all channels.
- filt_en  in  CH_NUM  per-channel filter enable; 0 = bypass.
- irq_en  in  CH_NUM  per-channel interrupt enable.
- flag_clr  in  CH_NUM  one-cycle clear pulse for the sticky flags.
- sync_level  out  CH_NUM  filtered, synchronised level.
- rise_pulse  out  CH_NUM  one-cycle pulse on a 0->1 change of sync_level.
- fall_pulse  out  CH_NUM  one-cycle pulse on a 1->0 change of sync_level.
- event_flag  out  CH_NUM  sticky "any edge since last clear".
- irq  out  1  OR-reduction of (event_flag & irq_en), registered.

Behaviour:
- Reset state: sync chain and sync_level = RST_VAL; counters, pulses, event_flag and irq = 0. Reset asserted mid-operation aborts any count in progress immediately.
- Synchroniser: async_in[i] passes STAGE_NUM flops. The last stage is s[i].
- Filter, per channel. Let Leff = (filt_en[i] && filt_len != 0) ? filt_len : 1.
  - s == sync_level: counter clears to 0.
  - s != sync_level: counter increments.
  - When the counter reaches Leff-1 and s still differs, sync_level toggles on the next edge and the counter clears.
  - Result: a change in s must persist Leff consecutive cycles to propagate.
  - Any reversion during the count clears the counter; a glitch shorter than Leff is fully suppressed.
- Total latency from a stable async_in change to sync_level is STAGE_NUM + Leff cycles (bypass: STAGE_NUM + 1).
- Counter saturation: the counter never exceeds 2^FILT_W - 1 and never wraps.
- filt_len change mid-count: the new value takes effect immediately. If counter >= new Leff-1 while s still differs, sync_level updates on the next edge.
- Edge pulses:
  - rise_pulse/fall_pulse are high exactly in the first cycle sync_level shows its new value.
  - They are registered and never both high for one channel.
  - No pulses are generated on reset release.
- event_flag[i]: set by rise_pulse[i] or fall_pulse[i]; cleared by flag_clr[i]. When set and clear coincide, set wins.
- irq: registered, one cycle after the flag change.
- Channels are fully independent; no cross-channel interaction except the shared filt_len.

Decomposition:
- Shared package rcc_sync_pkg: STAGE_NUM legal min/max constants; FILT_W default; the Leff computation as a function.
- One sub-module, rcc_sync_filter_ch: sync chain, counter, level, pulses and flag for a single channel. It is instantiated CH_NUM times via a generate loop.
- The top level contains only the generate loop and the irq reduction register.

Test Plan:
- Reset release with RST_VAL=0, async_in=0: all outputs 0 and no pulses. Then raise async_in[3] with filt_en=0 -> sync_level[3]=1 and rise_pulse[3] exactly 3 cycles later (STAGE_NUM=2).
- filt_en[0]=1, filt_len=4: a 3-cycle high glitch on async_in[0] -> no change on sync_level[0] and no pulse. A 4-cycle-stable high -> rise at 2+4=6 cycles after the input edge.
- Toggle async_in[5] 1->0 with irq_en[5]=1 -> fall_pulse[5] for one cycle, event_flag[5]=1, irq=1 one cycle later.
- flag_clr[5] asserted in the same cycle as a new rise_pulse[5] -> event_flag[5] stays 1.
- filt_len=8 with the counter at 5 on channel 1, then change filt_len to 3 -> sync_level[1] updates on the next edge.
- Assert rcc_rcc_sync_rst asynchronously mid-count on all channels -> outputs return to RST_VAL/0 without a clock edge, and no pulses follow deassertion.
